// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - read-side bus between the UART RX buffer and the I/O decoder
//
// Purpose: groups the register-read path of the buffered UART receiver.
// Signals:
//   read_strobe  decoder -> uart  pop request, level; a rising edge pops one byte
//   err_clear    decoder -> uart  clears the sticky error flags
//   data         uart -> decoder  byte at FIFO head (0 when empty)
//   ready        uart -> decoder  FIFO not empty
//   count        uart -> decoder  bytes currently stored (AW+1 bits)
//   overrun      uart -> decoder  sticky: byte dropped on a full FIFO
//   frame_err    uart -> decoder  sticky: stop bit sampled low
// Modports: master = I/O decoder side, slave = receiver side.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          read_strobe;
  logic          err_clear;
  logic [7:0]    data;
  logic          ready;
  logic [AW:0]   count;
  logic          overrun;
  logic          frame_err;

  modport master (
    output read_strobe, err_clear,
    input  data, ready, count, overrun, frame_err
  );

  modport slave (
    input  read_strobe, err_clear,
    output data, ready, count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with a show-ahead receive FIFO
//
// Purpose: deserialises 8N1 frames from rxd using a 16x baud strobe and
// buffers the received bytes so firmware can poll at its own pace.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   baudclk16  one-clk strobe at 16x the baud rate
//   rxd        serial input, idle high, asynchronous to clk
//   rd         read-side bus (slave modport): read_strobe, err_clear in;
//              data, ready, count, overrun, frame_err out
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           baudclk16,
  input  logic           rxd,
  uart_rx_fifo_if.slave  rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Synchroniser; both stages reset high so reset never looks like a start bit.
  logic rxd_meta_q, rxd_meta_d;
  logic rxs_q, rxs_d;

  state_t      state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shift_q, shift_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0] count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        read_strobe_d_q, read_strobe_d_d;

  logic [7:0]  mem [DEPTH];

  logic        push;
  logic        frame_set;
  logic        pop;
  logic        full;
  logic        wr_en;
  logic        ovr_set;

  assign rxd_meta_d = rxd;
  assign rxs_d      = rxd_meta_q;

  // Receive FSM; every decision uses the synchronised line rxs_q.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (baudclk16 && !rxs_q) begin
          state_d = S_START;
          tick_d  = 4'd0;
        end
      end
      S_START: begin
        if (baudclk16) begin
          if (tick_q == 4'd7) begin
            // Mid start bit: a high line here means it was only a glitch.
            if (!rxs_q) begin
              state_d = S_DATA;
              tick_d  = 4'd0;
              bitn_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (baudclk16) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {rxs_q, shift_q[7:1]};
            bitn_d  = bitn_q + 3'd1;
            if (bitn_q == 3'd7) begin
              state_d = S_STOP;
              tick_d  = 4'd0;
            end
          end
        end
      end
      S_STOP: begin
        if (baudclk16) begin
          if (tick_q == 4'd15) begin
            if (rxs_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line goes idle so a break is not decoded as 0x00 frames.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping. A push into a full FIFO is still accepted when a pop
  // frees the head slot on the same edge.
  always_comb begin
    pop             = rd.read_strobe && !read_strobe_d_q && (count_q != '0);
    full            = (count_q == FULL_COUNT);
    wr_en           = push && (!full || pop);
    ovr_set         = push && full && !pop;
    read_strobe_d_d = rd.read_strobe;
    rp_d            = pop   ? rp_q + 1'b1 : rp_q;
    wp_d            = wr_en ? wp_q + 1'b1 : wp_q;
    count_d         = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    // A set event on the same edge as err_clear wins.
    overrun_d   = ovr_set   || (overrun_q   && !rd.err_clear);
    frame_err_d = frame_set || (frame_err_q && !rd.err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q      <= 1'b1;
      rxs_q           <= 1'b1;
      state_q         <= S_IDLE;
      tick_q          <= 4'd0;
      bitn_q          <= 3'd0;
      shift_q         <= 8'd0;
      rp_q            <= '0;
      wp_q            <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      read_strobe_d_q <= 1'b0;
    end else begin
      rxd_meta_q      <= rxd_meta_d;
      rxs_q           <= rxs_d;
      state_q         <= state_d;
      tick_q          <= tick_d;
      bitn_q          <= bitn_d;
      shift_q         <= shift_d;
      rp_q            <= rp_d;
      wp_q            <= wp_d;
      count_q         <= count_d;
      overrun_q       <= overrun_d;
      frame_err_q     <= frame_err_d;
      read_strobe_d_q <= read_strobe_d_d;
    end
  end

  // Storage is not reset; count_q gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= shift_q;
    end
  end

  assign rd.ready     = (count_q != '0);
  assign rd.data      = (count_q != '0) ? mem[rp_q] : 8'd0;
  assign rd.count     = count_q;
  assign rd.overrun   = overrun_q;
  assign rd.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baudclk16 = 1'b0;
  logic rxd = 1'b1;
  logic [1:0] phase = 2'd0;

  int n_checks = 0;
  int n_fail = 0;

  uart_rx_fifo_if #(.AW(4)) rd_if ();

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .baudclk16 (baudclk16),
    .rxd       (rxd),
    .rd        (rd_if.slave)
  );

  always #5 clk = ~clk;

  // 16x strobe every 4 clk: one bit = 64 clk, one frame = 640 clk.
  always @(negedge clk) begin
    baudclk16 = (phase == 2'd3);
    phase = phase + 2'd1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end (got running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame. With pop_at_stop set, a read_strobe rising edge is
  // placed on exactly the clk edge where the receiver samples the stop bit:
  // the line change is seen by the FSM 3 edges later, the start is taken on
  // the first strobe from then on (edge k), and the stop sample falls 152
  // strobes (608 clk) after that.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    int k;
    int bi;
    step(1);
    k = 3;
    while (((int'(phase) + k - 1) % 4) != 3) k++;
    for (int j = 0; j < 640; j++) begin
      bi = j / 64;
      if (bi == 0) rxd = 1'b0;
      else if (bi <= 8) rxd = b[bi-1];
      else rxd = stop_bit;
      rd_if.read_strobe = pop_at_stop && (j >= k + 607) && (j <= k + 609);
      step(1);
    end
    rd_if.read_strobe = 1'b0;
  endtask

  task automatic pop_pulse();
    rd_if.read_strobe = 1'b1;
    step(1);
    rd_if.read_strobe = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    step(3);
    n_checks++; if (rd_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rd_if.data); end
    n_checks++; if (rd_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rd_if.ready); end
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rd_if.count); end
    n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", rd_if.overrun); end
    n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", rd_if.frame_err); end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_single_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", rd_if.ready); end
    n_checks++; if (rd_if.data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", rd_if.data); end
    n_checks++; if (rd_if.count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", rd_if.count); end
    pop_pulse();
    n_checks++; if (rd_if.ready !== 1'b0) begin n_fail++; $display("FAIL single_pop_ready: got %b expected 0", rd_if.ready); end
    n_checks++; if (rd_if.data !== 8'h00) begin n_fail++; $display("FAIL single_pop_data: got %h expected 00", rd_if.data); end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    step(12);
    rxd = 1'b1;
    step(100);
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", rd_if.count); end
    n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b expected 0", rd_if.frame_err); end
    n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_overrun: got %b expected 0", rd_if.overrun); end
    send_frame(8'h5A, 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.data !== 8'h5A) begin n_fail++; $display("FAIL glitch_after_data: got %h expected 5a", rd_if.data); end
    pop_pulse();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.count !== 5'd16) begin n_fail++; $display("FAIL ovr_count: got %0d expected 16", rd_if.count); end
    n_checks++; if (rd_if.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", rd_if.overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (rd_if.data !== 8'(i)) begin n_fail++; $display("FAIL ovr_read_%0d: got %h expected %h", i, rd_if.data, 8'(i)); end
      pop_pulse();
    end
    n_checks++; if (rd_if.ready !== 1'b0) begin n_fail++; $display("FAIL ovr_empty_ready: got %b expected 0", rd_if.ready); end
    pop_pulse();
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL ovr_empty_pop_count: got %0d expected 0", rd_if.count); end
    rd_if.err_clear = 1'b1;
    step(1);
    rd_if.err_clear = 1'b0;
    n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", rd_if.overrun); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.count !== 5'd16) begin n_fail++; $display("FAIL full_count_before: got %0d expected 16", rd_if.count); end
    send_frame(8'h55, 1'b1, 1'b1);
    step(4);
    n_checks++; if (rd_if.count !== 5'd16) begin n_fail++; $display("FAIL full_count_after: got %0d expected 16", rd_if.count); end
    n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL full_overrun: got %b expected 0", rd_if.overrun); end
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (rd_if.data !== 8'h21 + 8'(i)) begin n_fail++; $display("FAIL full_read_%0d: got %h expected %h", i, rd_if.data, 8'h21 + 8'(i)); end
      pop_pulse();
    end
    n_checks++; if (rd_if.data !== 8'h55) begin n_fail++; $display("FAIL full_last: got %h expected 55", rd_if.data); end
    pop_pulse();
    n_checks++; if (rd_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b expected 0", rd_if.ready); end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0);
    step(1280);
    n_checks++; if (rd_if.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b expected 1", rd_if.frame_err); end
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL ferr_count: got %0d expected 0", rd_if.count); end
    rxd = 1'b1;
    step(100);
    send_frame(8'h81, 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.count !== 5'd1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", rd_if.count); end
    n_checks++; if (rd_if.data !== 8'h81) begin n_fail++; $display("FAIL ferr_recover_data: got %h expected 81", rd_if.data); end
    rd_if.err_clear = 1'b1;
    step(1);
    rd_if.err_clear = 1'b0;
    n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", rd_if.frame_err); end
    pop_pulse();
  endtask

  task automatic test_held_strobe();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.count !== 5'd2) begin n_fail++; $display("FAIL held_count_before: got %0d expected 2", rd_if.count); end
    rd_if.read_strobe = 1'b1;
    step(2);
    rd_if.read_strobe = 1'b0;
    step(1);
    n_checks++; if (rd_if.count !== 5'd1) begin n_fail++; $display("FAIL held_count_after: got %0d expected 1", rd_if.count); end
    n_checks++; if (rd_if.data !== 8'h22) begin n_fail++; $display("FAIL held_data: got %h expected 22", rd_if.data); end
  endtask

  task automatic test_reset_mid_frame();
    // Start bit plus data bits 0..3 of 0x00, then reset inside bit 4.
    for (int j = 0; j < 64 * 5 + 20; j++) begin
      rxd = 1'b0;
      step(1);
    end
    reset = 1'b1;
    step(1);
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", rd_if.count); end
    n_checks++; if (rd_if.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", rd_if.ready); end
    n_checks++; if (rd_if.data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rd_if.data); end
    n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b expected 0", rd_if.frame_err); end
    reset = 1'b0;
    rxd = 1'b1;
    step(1300);
    n_checks++; if (rd_if.count !== 5'd0) begin n_fail++; $display("FAIL midrst_idle_count: got %0d expected 0", rd_if.count); end
    send_frame(8'h7E, 1'b1, 1'b0);
    step(4);
    n_checks++; if (rd_if.count !== 5'd1) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 1", rd_if.count); end
    n_checks++; if (rd_if.data !== 8'h7E) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 7e", rd_if.data); end
    n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", rd_if.overrun); end
  endtask

  initial begin
    rd_if.read_strobe = 1'b0;
    rd_if.err_clear = 1'b0;
    test_reset();
    test_single_frame();
    test_glitch();
    test_overrun();
    test_full_push_pop();
    test_frame_error();
    test_held_strobe();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
